// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FTDI 245-FIFO bridge.
package ftdi_pkg;

    localparam int FTDI_DATA_W = 8;

    // Bridge state machine states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR       = 3'd3,
        WR_HOLD  = 3'd4,
        TURN     = 3'd5
    } bridge_state_t;

    // Round-robin pointer: the side that wins the next tie.
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } rr_t;

    // Chooses which side to serve; only meaningful when rd_ok or wr_ok is set.
    function automatic rr_t arb_pick(input logic rd_ok, input logic wr_ok, input rr_t ptr);
        rr_t side;
        if (rd_ok && wr_ok) begin
            side = ptr;
        end else if (rd_ok) begin
            side = READ;
        end else begin
            side = WRITE;
        end
        return side;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO used for the RX and TX byte buffers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // A pop frees its slot in the same cycle, so a push into a full buffer is
    // accepted when it coincides with a pop; other overflow/underflow is dropped.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array written at the tail pointer.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ftdi_fifo_bridge.sv
// Arbitrated controller for the FTDI asynchronous 245-FIFO port with
// buffered valid/ready byte streams on the FPGA side.
module ftdi_fifo_bridge
    import ftdi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int RD_PULSE    = 4,
    parameter int WR_PULSE    = 4,
    parameter int TURNAROUND  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          rxf,
    input  logic                          txe,
    input  logic [FTDI_DATA_W-1:0]        adbus_in,
    output logic [FTDI_DATA_W-1:0]        adbus_out,
    output logic                          adbus_tri,
    output logic                          ftdi_rd,
    output logic                          ftdi_wr,
    output logic [FTDI_DATA_W-1:0]        rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic [FTDI_DATA_W-1:0]        tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic                          busy
);

    localparam int MAX_RW  = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int MAX_CNT = (MAX_RW > TURNAROUND) ? MAX_RW : TURNAROUND;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    // The IDLE cycle that follows TURN is itself the last idle cycle of the
    // turnaround, so TURN lasts one cycle fewer (and is skipped when only one
    // idle cycle is wanted). This gives RD_PULSE + TURNAROUND cycles per read.
    localparam int TURN_CYC = (TURNAROUND > 1) ? (TURNAROUND - 1) : 1;

    bridge_state_t r_state;
    bridge_state_t w_state_nx;
    rr_t           r_ptr;
    rr_t           w_ptr_nx;
    logic [CNT_W-1:0] r_cnt;

    logic [SYNC_STAGES-1:0] r_rxf_sync;
    logic [SYNC_STAGES-1:0] r_txe_sync;
    logic w_rxf_s;
    logic w_txe_s;

    logic                   r_ftdi_rd;
    logic                   r_ftdi_wr;
    logic                   r_adbus_tri;
    logic [FTDI_DATA_W-1:0] r_adbus_out;
    logic                   r_busy;

    logic                   w_rd_ok;
    logic                   w_wr_ok;
    logic                   w_rx_push;
    logic                   w_tx_pop;
    logic                   w_load_out;
    logic                   w_rx_pop;
    logic                   w_tx_push;
    logic                   w_rx_full;
    logic                   w_rx_empty;
    logic                   w_tx_full;
    logic                   w_tx_empty;
    logic [FTDI_DATA_W-1:0] w_tx_head;
    bridge_state_t          w_after_xfer;

    // RX buffer: filled from the FTDI bus, drained by the consumer.
    sync_fifo #(
        .WIDTH (FTDI_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_data  (adbus_in),
        .i_pop   (w_rx_pop),
        .o_data  (rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (rx_count)
    );

    // TX buffer: filled by the producer, drained onto the FTDI bus.
    sync_fifo #(
        .WIDTH (FTDI_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_tx_push),
        .i_data  (tx_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (tx_count)
    );

    assign rx_valid  = ~w_rx_empty;
    assign w_rx_pop  = rx_valid & rx_ready;
    assign tx_ready  = ~w_tx_full | w_tx_pop;
    assign w_tx_push = tx_valid & tx_ready;

    assign w_rxf_s = r_rxf_sync[SYNC_STAGES-1];
    assign w_txe_s = r_txe_sync[SYNC_STAGES-1];

    assign w_rd_ok = en & ~w_rxf_s & ~w_rx_full;
    assign w_wr_ok = en & ~w_txe_s & ~w_tx_empty;

    assign w_after_xfer = (TURNAROUND > 1) ? TURN : IDLE;

    // Metastability synchronisers for the asynchronous FTDI flags (idle high).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rxf_sync <= {SYNC_STAGES{1'b1}};
            r_txe_sync <= {SYNC_STAGES{1'b1}};
        end else begin
            r_rxf_sync <= {r_rxf_sync[SYNC_STAGES-2:0], rxf};
            r_txe_sync <= {r_txe_sync[SYNC_STAGES-2:0], txe};
        end
    end

    // Next-state, arbitration and buffer strobes.
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_rx_push  = 1'b0;
        w_tx_pop   = 1'b0;
        w_load_out = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rd_ok || w_wr_ok) begin
                    if (arb_pick(w_rd_ok, w_wr_ok, r_ptr) == READ) begin
                        w_state_nx = RD;
                        w_ptr_nx   = WRITE;
                    end else begin
                        w_state_nx = WR_SETUP;
                        w_ptr_nx   = READ;
                        w_load_out = 1'b1;
                    end
                end else begin
                    w_state_nx = IDLE;
                end
            end
            RD: begin
                if (r_cnt == CNT_W'(RD_PULSE - 1)) begin
                    w_rx_push  = 1'b1;
                    w_state_nx = w_after_xfer;
                end else begin
                    w_state_nx = RD;
                end
            end
            WR_SETUP: begin
                w_state_nx = WR;
            end
            WR: begin
                if (r_cnt == CNT_W'(WR_PULSE - 1)) begin
                    w_tx_pop   = 1'b1;
                    w_state_nx = WR_HOLD;
                end else begin
                    w_state_nx = WR;
                end
            end
            WR_HOLD: begin
                w_state_nx = w_after_xfer;
            end
            TURN: begin
                if (r_cnt == CNT_W'(TURN_CYC - 1)) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = TURN;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State, arbitration pointer and in-state cycle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= READ;
            r_cnt   <= CNT_W'(0);
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            if ((w_state_nx != r_state) || (r_state == IDLE)) begin
                r_cnt <= CNT_W'(0);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Pin outputs registered from the next state so they track r_state glitch-free.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ftdi_rd   <= 1'b1;
            r_ftdi_wr   <= 1'b1;
            r_adbus_tri <= 1'b0;
            r_adbus_out <= FTDI_DATA_W'(0);
            r_busy      <= 1'b0;
        end else begin
            r_ftdi_rd   <= (w_state_nx != RD);
            r_ftdi_wr   <= (w_state_nx != WR);
            r_adbus_tri <= (w_state_nx == WR_SETUP) || (w_state_nx == WR) ||
                           (w_state_nx == WR_HOLD);
            r_busy      <= (w_state_nx != IDLE);
            if (w_load_out) begin
                r_adbus_out <= w_tx_head;
            end
        end
    end

    assign ftdi_rd   = r_ftdi_rd;
    assign ftdi_wr   = r_ftdi_wr;
    assign adbus_tri = r_adbus_tri;
    assign adbus_out = r_adbus_out;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Self-checking bench: an FTDI chip model plus RX/TX scoreboards.
module tb_ftdi_fifo_bridge;

    localparam int DEPTH = 4;
    localparam int RDP   = 4;
    localparam int WRP   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock;
    logic          reset;
    logic          en;
    logic          rxf;
    logic          txe;
    logic [7:0]    adbus_in;
    logic [7:0]    adbus_out;
    logic          adbus_tri;
    logic          ftdi_rd;
    logic          ftdi_wr;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] tx_count;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] chip_q[$];   // bytes the FTDI chip still has to offer
    logic [7:0] exp_rx[$];   // bytes the consumer must see, in order
    logic [7:0] exp_tx[$];   // bytes the FTDI chip must receive, in order
    int         op_log[$];   // 0 = read, 1 = write, in start order
    int         rd_pulses = 0;
    int         wr_pulses = 0;
    bit         force_rxf_high = 1'b0;
    bit         rand_hold_en = 1'b0;

    ftdi_fifo_bridge #(
        .FIFO_DEPTH  (DEPTH),
        .RD_PULSE    (RDP),
        .WR_PULSE    (WRP),
        .TURNAROUND  (2),
        .SYNC_STAGES (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .rxf       (rxf),
        .txe       (txe),
        .adbus_in  (adbus_in),
        .adbus_out (adbus_out),
        .adbus_tri (adbus_tri),
        .ftdi_rd   (ftdi_rd),
        .ftdi_wr   (ftdi_wr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_count  (rx_count),
        .tx_count  (tx_count),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no expected entry / timeout, expected event", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        chip_q.delete();
        exp_rx.delete();
        exp_tx.delete();
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic chip_offer(input logic [7:0] b);
        chip_q.push_back(b);
        exp_rx.push_back(b);
    endtask

    task automatic push_tx(input logic [7:0] b);
        bit ok;
        int k;
        ok = 1'b0;
        k = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!ok && k < 100) begin
            @(negedge clock);
            ok = tx_ready;
            tick();
            k++;
        end
        tx_valid = 1'b0;
        if (!ok) fail_now("push_tx");
    endtask

    // FTDI chip model: offers bytes while it has any, goes not-ready during a
    // strobe, consumes a byte when RD# rises.
    logic rd_prev = 1'b1;
    always @(negedge clock) begin
        if (!reset && rd_prev == 1'b0 && ftdi_rd == 1'b1 && chip_q.size() > 0)
            void'(chip_q.pop_front());
        rd_prev  = ftdi_rd;
        rxf      = force_rxf_high || (rand_hold_en && $urandom_range(0, 7) == 0) ||
                   (chip_q.size() == 0) || (ftdi_rd == 1'b0);
        txe      = (rand_hold_en && $urandom_range(0, 7) == 0) || (ftdi_wr == 1'b0);
        adbus_in = (chip_q.size() > 0) ? chip_q[0] : 8'($urandom);
    end

    // Monitor: protocol invariants, strobe widths and both scoreboards.
    int   rd_low = 0;
    int   wr_low = 0;
    logic m_rd_prev = 1'b1;
    logic m_wr_prev = 1'b1;
    logic prev_tri = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            rd_low    = 0;
            wr_low    = 0;
            m_rd_prev = 1'b1;
            m_wr_prev = 1'b1;
            prev_tri  = 1'b0;
        end else begin
            check("strobes_exclusive", 32'(ftdi_rd == 1'b0 && ftdi_wr == 1'b0), 32'd0);
            check("tri_while_rd", 32'(ftdi_rd == 1'b0 && adbus_tri == 1'b1), 32'd0);
            if (ftdi_rd == 1'b0) begin
                if (m_rd_prev) begin
                    op_log.push_back(0);
                    rd_pulses++;
                    check("rd_when_full", 32'(rx_count >= DEPTH), 32'd0);
                end
                rd_low++;
            end else if (m_rd_prev == 1'b0) begin
                check("rd_width", rd_low, RDP);
                rd_low = 0;
            end
            if (ftdi_wr == 1'b0) begin
                if (m_wr_prev) begin
                    op_log.push_back(1);
                    wr_pulses++;
                    check("tri_before_wr", 32'(prev_tri), 32'd1);
                end
                wr_low++;
                check("tri_during_wr", 32'(adbus_tri), 32'd1);
                if (exp_tx.size() > 0) check("wr_data", adbus_out, exp_tx[0]);
            end else if (m_wr_prev == 1'b0) begin
                check("wr_width", wr_low, WRP);
                wr_low = 0;
                check("tri_hold", 32'(adbus_tri), 32'd1);
                if (exp_tx.size() == 0) fail_now("tx_byte");
                else check("tx_byte", adbus_out, exp_tx.pop_front());
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) fail_now("rx_byte");
                else check("rx_byte", rx_data, exp_rx.pop_front());
            end
            if (tx_valid && tx_ready) exp_tx.push_back(tx_data);
            m_rd_prev = ftdi_rd;
            m_wr_prev = ftdi_wr;
            prev_tri  = adbus_tri;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no end of run, expected finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int k;
        int base;
        reset    = 1'b1;
        en       = 1'b0;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        check("rst_rd", 32'(ftdi_rd), 32'd1);
        check("rst_wr", 32'(ftdi_wr), 32'd1);
        check("rst_tri", 32'(adbus_tri), 32'd0);
        check("rst_out", adbus_out, 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_count", rx_count, 32'd0);
        check("rst_tx_count", tx_count, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // Single read of A5.
        en = 1'b1;
        chip_offer(8'hA5);
        k = 0;
        while (ftdi_rd && k < 20) begin tick(); k++; end
        check("rd_latency", 32'(k >= 2 && k <= 4), 32'd1);
        k = 0;
        while (busy && k < 40) begin tick(); k++; end
        check("rd_done", 32'(k < 40), 32'd1);
        check("rd_rx_valid", 32'(rx_valid), 32'd1);
        check("rd_rx_data", rx_data, 32'hA5);
        check("rd_rx_count", rx_count, 32'd1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rd_pop_count", rx_count, 32'd0);

        // Single write of 3C.
        push_tx(8'h3C);
        k = 0;
        while (ftdi_wr && k < 30) begin tick(); k++; end
        check("wr_started", 32'(k < 30), 32'd1);
        check("wr_tx_count1", tx_count, 32'd1);
        k = 0;
        while (busy && k < 40) begin tick(); k++; end
        check("wr_tx_count0", tx_count, 32'd0);
        check("wr_tx_ready", 32'(tx_ready), 32'd1);

        // Reset in the middle of a write strobe.
        push_tx(8'h5A);
        k = 0;
        while (ftdi_wr && k < 30) begin tick(); k++; end
        tick();
        check("mid_wr_low", 32'(ftdi_wr), 32'd0);
        reset = 1'b1;
        tx_valid = 1'b0;
        chip_q.delete();
        exp_rx.delete();
        exp_tx.delete();
        tick();
        check("rst_mid_wr", 32'(ftdi_wr), 32'd1);
        check("rst_mid_tri", 32'(adbus_tri), 32'd0);
        check("rst_mid_tx_count", tx_count, 32'd0);
        check("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
        tick();
        reset = 1'b0;

        // Contention: reads and writes alternate.
        en = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) chip_offer(8'(8'h10 + i));
        for (int i = 0; i < 3; i++) push_tx(8'(8'hC0 + i));
        rx_ready = 1'b1;
        op_log.delete();
        en = 1'b1;
        k = 0;
        while ((exp_rx.size() != 0 || exp_tx.size() != 0 || busy) && k < 400) begin tick(); k++; end
        check("cont_drained", 32'(k < 400), 32'd1);
        check("cont_ops", 32'(op_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < op_log.size(); i++) check("cont_order", op_log[i], i % 2);

        // RX full: exactly DEPTH reads, then one more per pop.
        do_reset();
        en = 1'b1;
        base = rd_pulses;
        for (int i = 0; i < 8; i++) chip_offer(8'($urandom));
        repeat (100) tick();
        check("full_reads", rd_pulses - base, DEPTH);
        check("full_count", rx_count, DEPTH);
        check("full_rd_idle", 32'(ftdi_rd), 32'd1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (60) tick();
        check("full_one_more", rd_pulses - base, DEPTH + 1);
        check("full_count2", rx_count, DEPTH);
        rx_ready = 1'b1;
        k = 0;
        while (exp_rx.size() != 0 && k < 300) begin tick(); k++; end
        check("full_drain", 32'(k < 300), 32'd1);

        // en drop and rxf release during the second read cycle.
        do_reset();
        en = 1'b1;
        rx_ready = 1'b1;
        chip_offer(8'h96);
        chip_offer(8'h69);
        k = 0;
        while (ftdi_rd && k < 20) begin tick(); k++; end
        tick();
        base = rd_pulses;
        en = 1'b0;
        force_rxf_high = 1'b1;
        repeat (40) tick();
        check("endrop_pushed", exp_rx.size(), 32'd1);
        check("endrop_no_new", rd_pulses - base, 32'd0);
        check("endrop_idle", 32'(busy), 32'd0);
        en = 1'b1;
        force_rxf_high = 1'b0;
        k = 0;
        while (exp_rx.size() != 0 && k < 100) begin tick(); k++; end
        check("endrop_resume", 32'(k < 100), 32'd1);

        // Randomised traffic.
        do_reset();
        rand_hold_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            rx_ready = ($urandom_range(0, 2) != 0);
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            if (chip_q.size() < 6 && $urandom_range(0, 3) == 0) chip_offer(8'($urandom));
            tick();
        end
        tx_valid = 1'b0;
        en = 1'b1;
        rx_ready = 1'b1;
        rand_hold_en = 1'b0;
        k = 0;
        while ((exp_rx.size() != 0 || exp_tx.size() != 0 || busy) && k < 3000) begin tick(); k++; end
        check("rand_drained", 32'(k < 3000), 32'd1);
        check("rand_rx_count", rx_count, 32'd0);
        check("rand_tx_count", tx_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
